// File: rtl/code_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational code datapath.
// Each job runs IDLE (grant) -> DRIVE (capture) -> HOLD (handshake or watchdog drop).
module code_arbiter #(
  parameter int          bus_width = 32,
  parameter logic [7:0]  dog_width = 8'b10101100
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [2:0]         req0_sel,
  input  logic [2:0]         req1_sel,
  input  logic [bus_width:0] req0_a,
  input  logic [bus_width:0] req0_b,
  input  logic [bus_width:0] req1_a,
  input  logic [bus_width:0] req1_b,
  output logic [2:0]         dp_sel,
  output logic [bus_width:0] dp_a,
  output logic [bus_width:0] dp_b,
  input  logic [7:0]         dp_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_code,
  output logic               out_id,
  output logic               err_timeout
);

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t     state, nstate;
  logic       last;
  logic       gnt_id;
  logic       gnt_q;
  logic       grant;
  logic       accept;
  logic       drop;
  logic [7:0] cnt;

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign gnt_id = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign grant  = (state == IDLE) & (req0_valid | req1_valid);
  assign accept = (state == HOLD) & out_ready;
  assign drop   = (state == HOLD) & ~out_ready & (dog_width != 8'd0) &
                  (cnt == dog_width - 8'd1);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (grant) nstate = DRIVE;
      DRIVE:   nstate = HOLD;
      HOLD:    if (accept | drop) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (grant && !reset) begin
      req0_ready = ~gnt_id;
      req1_ready = gnt_id;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      dp_sel <= 3'b000;
      dp_a   <= '0;
      dp_b   <= '0;
      gnt_q  <= 1'b0;
    end else if (grant) begin
      dp_sel <= gnt_id ? req1_sel : req0_sel;
      dp_a   <= gnt_id ? req1_a   : req0_a;
      dp_b   <= gnt_id ? req1_b   : req0_b;
      gnt_q  <= gnt_id;
    end
  end

  // Result capture, watchdog and round-robin pointer.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_code    <= 8'h00;
      out_id      <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= 8'd0;
      last        <= 1'b1;
    end else begin
      err_timeout <= drop;
      if (state == DRIVE) begin
        out_code  <= dp_code;
        out_id    <= gnt_q;
        out_valid <= 1'b1;
        cnt       <= 8'd0;
      end else if (state == HOLD) begin
        if (accept | drop) begin
          out_valid <= 1'b0;
          last      <= out_id;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_code_arbiter.sv
// Directed bench for code_arbiter; watchdog limit shortened to 4 cycles.
module tb_code_arbiter;
  localparam int BW = 32;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]    req0_sel, req1_sel, dp_sel;
  logic [BW:0]   req0_a, req0_b, req1_a, req1_b, dp_a, dp_b;
  logic [7:0]    dp_code, out_code;
  logic          out_valid, out_ready, out_id, err_timeout;
  int            tests = 0;
  int            failed = 0;

  code_arbiter #(.bus_width(BW), .dog_width(8'd4)) dut (
    .sysclk(sysclk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .dp_sel(dp_sel), .dp_a(dp_a), .dp_b(dp_b), .dp_code(dp_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_id(out_id), .err_timeout(err_timeout)
  );

  always #5 sysclk = ~sysclk;

  // Datapath model: sel 2 yields 8'hFF, otherwise a + b + sel on the low byte.
  always_comb begin
    dp_code = (dp_sel == 3'b010) ? 8'hFF : (dp_a[7:0] + dp_b[7:0] + {5'b0, dp_sel});
  end

  task automatic cyc();
    @(posedge sysclk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    req0_sel = 3'd1; req0_a = 33'd5;  req0_b = 33'd6;
    req1_sel = 3'd3; req1_a = 33'd10; req1_b = 33'd20;
    #3;
    tests++; if (out_valid !== 1'b0 || err_timeout !== 1'b0) begin failed++; $display("FAIL rst_out got=%b%b exp=00", out_valid, err_timeout); end
    tests++; if (out_code !== 8'h00 || out_id !== 1'b0) begin failed++; $display("FAIL rst_code got=%h/%b exp=00/0", out_code, out_id); end
    tests++; if (dp_sel !== 3'b000 || dp_a !== '0 || dp_b !== '0) begin failed++; $display("FAIL rst_dp got=%0d/%0d/%0d exp=0/0/0", dp_sel, dp_a, dp_b); end
    cyc();
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failed++; $display("FAIL rst_ready got=%b%b exp=00", req0_ready, req1_ready); end
  endtask

  task automatic test_first_grant();
    reset = 1'b0; #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failed++; $display("FAIL first_gnt got=%b%b exp=10", req0_ready, req1_ready); end
    cyc(); req0_valid = 1'b0; #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || dp_sel !== 3'd1 || dp_a !== 33'd5) begin failed++; $display("FAIL first_drive got=%b%b sel=%0d a=%0d exp=00 1 5", req0_ready, req1_ready, dp_sel, dp_a); end
    cyc();
    tests++; if (out_valid !== 1'b1 || out_code !== 8'd12 || out_id !== 1'b0) begin failed++; $display("FAIL first_hold got=%b %0d %b exp=1 12 0", out_valid, out_code, out_id); end
    tests++; if (req1_ready !== 1'b0) begin failed++; $display("FAIL first_hold_rdy got=%b exp=0", req1_ready); end
    cyc();
    tests++; if (out_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failed++; $display("FAIL second_gnt got=v%b r%b%b exp=v0 r01", out_valid, req0_ready, req1_ready); end
    cyc(); req1_valid = 1'b0;
    cyc();
    tests++; if (out_valid !== 1'b1 || out_code !== 8'd33 || out_id !== 1'b1) begin failed++; $display("FAIL second_hold got=%b %0d %b exp=1 33 1", out_valid, out_code, out_id); end
    cyc();
  endtask

  task automatic test_req1_alone();
    req1_valid = 1'b1; req1_sel = 3'b010; req1_a = 33'h1_0000_00AB; req1_b = 33'd7; out_ready = 1'b1; #1;
    tests++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failed++; $display("FAIL alone_gnt got=%b%b exp=01", req0_ready, req1_ready); end
    cyc(); req1_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL alone_lat1 got=%b exp=0", out_valid); end
    cyc();
    tests++; if (out_valid !== 1'b1 || out_code !== 8'hFF || out_id !== 1'b1) begin failed++; $display("FAIL alone_hold got=%b %h %b exp=1 ff 1", out_valid, out_code, out_id); end
    cyc();
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL alone_done got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic       e;
    logic [7:0] ec;
    req0_sel = 3'd1; req0_a = 33'd3; req0_b = 33'd4;
    req1_sel = 3'd4; req1_a = 33'd7; req1_b = 33'd9;
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e  = (k % 2 == 1);
      ec = e ? 8'd20 : 8'd8;
      #1;
      tests++; if (req0_ready !== ~e || req1_ready !== e) begin failed++; $display("FAIL b2b_gnt%0d got=%b%b exp=%b%b", k, req0_ready, req1_ready, ~e, e); end
      cyc();
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failed++; $display("FAIL b2b_gap1_%0d got=%b%b exp=00", k, req0_ready, req1_ready); end
      cyc();
      tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_id !== e || out_code !== ec) begin failed++; $display("FAIL b2b_hold%0d got=%b%b id=%b code=%0d exp=00 id=%b code=%0d", k, req0_ready, req1_ready, out_id, out_code, e, ec); end
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    req0_valid = 1'b1; req0_sel = 3'd5; req0_a = 33'd1; req0_b = 33'd2; out_ready = 1'b0; #1;
    tests++; if (req0_ready !== 1'b1) begin failed++; $display("FAIL to_gnt got=%b exp=1", req0_ready); end
    cyc(); req0_valid = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      tests++; if (out_valid !== 1'b1 || err_timeout !== 1'b0) begin failed++; $display("FAIL to_hold%0d got=v%b e%b exp=v1 e0", i, out_valid, err_timeout); end
      cyc();
    end
    tests++; if (out_valid !== 1'b0 || err_timeout !== 1'b1) begin failed++; $display("FAIL to_drop got=v%b e%b exp=v0 e1", out_valid, err_timeout); end
    req0_valid = 1'b1; req1_valid = 1'b1; req1_sel = 3'd3; req1_a = 33'd10; req1_b = 33'd20; #1;
    tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin failed++; $display("FAIL to_next_gnt got=%b%b exp=01", req0_ready, req1_ready); end
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    tests++; if (err_timeout !== 1'b0) begin failed++; $display("FAIL to_pulse_len got=%b exp=0", err_timeout); end
    cyc();
    tests++; if (out_id !== 1'b1 || out_code !== 8'd33) begin failed++; $display("FAIL to_next_hold got=%b %0d exp=1 33", out_id, out_code); end
    cyc();
  endtask

  task automatic test_late_accept();
    req0_valid = 1'b1; req0_sel = 3'd0; req0_a = 33'd40; req0_b = 33'd2; out_ready = 1'b0;
    cyc(); req0_valid = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      tests++; if (out_valid !== 1'b1 || out_code !== 8'd42) begin failed++; $display("FAIL late_hold%0d got=%b %0d exp=1 42", i, out_valid, out_code); end
      cyc();
    end
    tests++; if (out_valid !== 1'b0 || err_timeout !== 1'b0) begin failed++; $display("FAIL late_acc got=v%b e%b exp=v0 e0", out_valid, err_timeout); end
    cyc();
    tests++; if (err_timeout !== 1'b0) begin failed++; $display("FAIL late_noerr got=%b exp=0", err_timeout); end
  endtask

  task automatic test_reset_hold();
    req1_valid = 1'b1; req1_sel = 3'd6; req1_a = 33'd1; req1_b = 33'd1; out_ready = 1'b0;
    cyc(); req1_valid = 1'b0;
    cyc(); cyc();
    tests++; if (out_valid !== 1'b1 || out_id !== 1'b1) begin failed++; $display("FAIL rh_pre got=%b %b exp=1 1", out_valid, out_id); end
    #2 reset = 1'b1; #1;
    tests++; if (out_valid !== 1'b0 || err_timeout !== 1'b0 || out_id !== 1'b0 || out_code !== 8'h00) begin failed++; $display("FAIL rh_async got=v%b e%b id%b c%h exp=v0 e0 id0 c00", out_valid, err_timeout, out_id, out_code); end
    cyc();
    tests++; if (err_timeout !== 1'b0) begin failed++; $display("FAIL rh_noerr got=%b exp=0", err_timeout); end
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; req0_sel = 3'd7; #1;
    tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failed++; $display("FAIL rh_gnt got=%b%b exp=10", req0_ready, req1_ready); end
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    tests++; if (dp_sel !== 3'd7) begin failed++; $display("FAIL rh_dp got=%0d exp=7", dp_sel); end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_req1_alone();
    test_back_to_back();
    test_timeout();
    test_late_accept();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/code_arbiter.md
CODE_ARBITER -- requirements
Module: code_arbiter

Interface
REQ-001 Parameter bus_width, default 32: operands are bus_width+1 bits wide ([bus_width:0]).
REQ-002 Parameter dog_width, default 8'b10101100 (172): watchdog limit in cycles; 0 disables the watchdog.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 Ports, clock and reset first:
- sysclk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid, req1_valid  in  1 each  requester has a job pending.
- req0_ready, req1_ready  out  1 each  job accepted this cycle.
- req0_sel, req1_sel  in  3 each  code-select for the shared code datapath.
- req0_a, req0_b, req1_a, req1_b  in  bus_width+1 each  operands.
- dp_sel  out  3  registered select to the shared datapath.
- dp_a, dp_b  out  bus_width+1 each  registered operands to the shared datapath.
- dp_code  in  8  combinational code result from the datapath.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_code  out  8  captured result.
- out_id  out  1  requester that owns out_code.
- err_timeout  out  1  one-cycle pulse when a result is dropped.

Function
REQ-005 The FSM SHALL have three states: IDLE, DRIVE and HOLD.
REQ-006 In IDLE, with any reqN_valid high, the block SHALL grant exactly one requester, assert its reqN_ready combinationally that cycle, and register its sel/a/b into dp_sel/dp_a/dp_b; the next state is DRIVE.
REQ-007 Arbitration SHALL be round-robin. When both requesters are valid, the grant goes to the requester that was not granted last. When only one is valid, it is granted regardless of history.
REQ-008 reqN_ready SHALL be 0 outside IDLE, and 0 for any requester that is not granted.
REQ-009 In DRIVE, the block SHALL capture dp_code into out_code and the grantee into out_id, and set out_valid=1; the next state is HOLD.
REQ-010 Latency: out_valid SHALL rise exactly 2 cycles after the accepting edge.
REQ-011 In HOLD, out_valid=1, and out_code and out_id SHALL remain stable until the job is accepted or dropped.
REQ-012 In HOLD, out_valid & out_ready SHALL complete the job. At that edge the last-grant pointer updates to out_id, out_valid clears, and the next state is IDLE.
REQ-013 The watchdog counter SHALL be 8 bits, clear to 0 on entry to HOLD, and increment on every HOLD cycle with out_ready=0.
REQ-014 If dog_width≠0, in HOLD, with out_ready=0 and counter==dog_width-1, the block SHALL drop the result: clear out_valid, pulse err_timeout for the next cycle, update the last-grant pointer, and go to IDLE.
REQ-015 Acceptance SHALL take priority over timeout in the same cycle.
REQ-016 Throughput SHALL be at most one job per 3 cycles. No new grant may occur before IDLE is re-entered.
REQ-017 dp_sel/dp_a/dp_b SHALL hold their last values outside the grant cycle.
REQ-018 A requester that deasserts valid before it is granted SHALL lose nothing and cause no error.

Reset
REQ-019 Asserting reset SHALL immediately force the following, independent of sysclk: state=IDLE, out_valid=0, err_timeout=0, out_code=8'h00, out_id=0, dp_sel=3'b000, dp_a=0, dp_b=0, counter=0, last-grant=1 (req0 wins first).
REQ-020 reqN_ready SHALL be 0 while reset is high.
REQ-021 An in-flight job SHALL be discarded on reset without an err_timeout pulse.
REQ-022 After release, the first grant SHALL be possible on the first rising edge with reset low.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset released; req0_valid=req1_valid=1 simultaneously -> req0_ready on cycle 1; req1_ready on the first IDLE cycle after job 0 is accepted.
- req1 alone, sel=3'b010, dp_code model returns 8'hFF, out_ready=1 -> out_valid 2 cycles after acceptance, out_code=8'hFF, out_id=1.
- Both requesters held valid, out_ready=1 -> grants alternate 0,1,0,1; a grant every 3 cycles.
- dog_width=4, out_ready held 0 -> out_valid high exactly 4 cycles, then err_timeout=1 for 1 cycle, then the next grant goes to the other requester.
- dog_width=4, out_ready rises on the 4th HOLD cycle -> job accepted, no err_timeout.
- Reset asserted during HOLD -> out_valid=0 asynchronously, no err_timeout; after release req0 is granted first.
